// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator: FSM states,
// the multiplier product width and the burst-counter width helper.
package prod_accumulator_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int cnt_w(input int count);
    return $clog2(count);
  endfunction

endpackage

// File: rtl/prod_accumulator_acc_add.sv
// Combinational accumulate adder: zero-extends a product onto the running
// sum and returns the wrapped sum together with the carry out of the top bit.
module acc_add
  import prod_accumulator_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] din,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  assign wide  = {1'b0, acc} + (ACC_W + 1)'(din);
  assign sum   = wide[ACC_W-1:0];
  assign carry = wide[ACC_W];

endmodule

// File: rtl/prod_accumulator.sv
// Sums bursts of COUNT unsigned products into an ACC_W-bit accumulator and
// hands each burst total downstream over a valid/ready handshake.
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int ACC_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int             CNT_W = cnt_w(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .acc   (acc_q),
    .din   (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    out_ovf_d = out_ovf_q;
    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      ovf_d     = 1'b0;
      sum_d     = '0;
      out_ovf_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = ACC_W'(in_data);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              sum_d     = add_sum;
              out_ovf_d = ovf_q | add_carry;
              cnt_d     = '0;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: bursts push expected totals, the
// result phase of each scenario pops and compares them.
module tb_prod_accumulator;

  localparam int COUNT = 8;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  exp_t sb[$];

  prod_accumulator #(
    .COUNT (COUNT),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) xfers++;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic burst(input logic [15:0] d, input bit push);
    longint unsigned tot = 0;
    exp_t e;
    for (int i = 0; i < COUNT; i++) begin
      drive(d);
      tot += d;
    end
    if (push) begin
      e.sum = tot[ACC_W-1:0];
      e.ovf = (tot > 64'd262143);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    longint unsigned tot = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int v = 1; v <= COUNT; v++) begin
      drive(16'(v));
      tot += v;
    end
    e.sum = tot[ACC_W-1:0]; e.ovf = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
    e = sb.pop_front();
    checks++; if (out_sum !== 18'h00024 || out_sum !== e.sum) begin failures++; $display("FAIL basic_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL basic_ovf got=%b exp=%b", out_ovf, e.ovf); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_overflow;
    exp_t e;
    out_ready = 1'b1;
    burst(16'hFE01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 18'h3F008 || out_sum !== e.sum) begin failures++; $display("FAIL ovf_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== 1'b1 || out_ovf !== e.ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", out_ovf, e.ovf); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int x0;
    out_ready = 1'b0;
    x0 = xfers;
    burst(16'hFE01, 1'b1);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
      checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL bp_sum[%0d] got=%h exp=%h", k, out_sum, e.sum); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    checks++; if (xfers - x0 !== 1) begin failures++; $display("FAIL bp_xfers got=%0d exp=1", xfers - x0); end
    burst(16'h0001, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_sum !== 18'd8 || out_sum !== e.sum) begin failures++; $display("FAIL bp_next_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL bp_next_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_gaps;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < COUNT; i++) begin
      drive(16'h1000);
      if (i < COUNT - 1) begin
        idle(2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid[%0d] got=%b exp=0", i, out_valid); end
      end
    end
    e.sum = 18'h08000; e.ovf = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== e.sum) begin failures++; $display("FAIL gap_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== e.ovf) begin failures++; $display("FAIL gap_ovf got=%b exp=%b", out_ovf, e.ovf); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_clear;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(16'h5555);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
    burst(16'h0002, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_sum !== 18'd16 || out_sum !== e.sum) begin failures++; $display("FAIL clr_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
    out_ready = 1'b0;
    burst(16'h0009, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_hold_valid got=%b exp=1", out_valid); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_hold_drop got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    burst(16'h0003, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_sum !== 18'd24 || out_sum !== e.sum) begin failures++; $display("FAIL clr_after_hold_sum got=%h exp=%h", out_sum, e.sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_hold;
    exp_t e;
    out_ready = 1'b0;
    burst(16'h0100, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_hold_valid got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== '0) begin failures++; $display("FAIL rst_async_sum got=%h exp=0", out_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    burst(16'h0005, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (out_sum !== 18'd40 || out_sum !== e.sum) begin failures++; $display("FAIL rst_after_sum got=%h exp=%h", out_sum, e.sum); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL rst_after_ovf got=%b exp=0", out_ovf); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_gaps();
    test_clear();
    test_reset_hold();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_drained got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
